// File: rtl/draw_sprite_scan.sv
// draw_sprite_scan: scans a 20x20 right-facing Pac-Man sprite one pixel per
// clock and emits VGA-adapter pixel writes, then holds done_print until the
// requester drops writeEn.
//
// Optional feature macro: SPRITE_ERASE_EN. When defined, this adds an `erase`
// input that is sampled on acceptance and forces colour to 0 for that print.
//
// Ports:
//   clock, resetn     - rising-edge clock, asynchronous active-low reset
//   writeEn           - level request, held high for the whole print
//   startx, starty    - sprite origin, latched on acceptance
//   erase             - (SPRITE_ERASE_EN only) blank print, latched on acceptance
//   x, y, colour, plot- registered pixel write to the VGA adapter
//   done_print        - print complete, held while writeEn stays high
//   busy              - scan in progress
module draw_sprite_scan #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 20,
    parameter int unsigned X_MAX  = 160,
    parameter int unsigned Y_MAX  = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       writeEn,
    input  logic [7:0] startx,
    input  logic [6:0] starty,
`ifdef SPRITE_ERASE_EN
    input  logic       erase,
`endif
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       colour,
    output logic       plot,
    output logic       done_print,
    output logic       busy
);

    localparam int unsigned CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          cnt_vld_q, cnt_vld_d;
    logic [7:0]    sx_q, sx_d;
    logic [6:0]    sy_q, sy_d;
    logic          erase_q, erase_d;
    logic          issue;

    // Stage 1: computed pixel for the index issued by the counters
    logic          s1_vld_q, s1_last_q, s1_inb_q, s1_body_q;
    logic [7:0]    s1_x_q;
    logic [6:0]    s1_y_q;

    // Output stage
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic          colour_q, plot_q, out_last_q, done_q, busy_q;

    logic          last_col, last_row;
    logic [5:0]    dx, dy, adx, ady;
    logic [7:0]    sq_x, sq_y;
    logic [8:0]    dist2;
    logic          mouth, body;
    logic [8:0]    px;
    logic [7:0]    py;
    logic          inb;

    assign last_col = (col_q == CW'(WIDTH - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));

    // Sprite shape: disc of radius 10 around (10,10) minus a right-facing wedge
    assign dx    = 6'(col_q) - 6'd10;
    assign dy    = 6'(row_q) - 6'd10;
    assign adx   = dx[5] ? (6'd0 - dx) : dx;
    assign ady   = dy[5] ? (6'd0 - dy) : dy;
    assign sq_x  = 8'(adx) * 8'(adx);
    assign sq_y  = 8'(ady) * 8'(ady);
    assign dist2 = 9'(sq_x) + 9'(sq_y);
    assign mouth = !dx[5] && (dx != 6'd0) && ({ady, 1'b0} <= {1'b0, adx});
    assign body  = (dist2 <= 9'd100) && !mouth;

    // Screen address, one bit wider than the outputs so overflow clips
    assign px  = 9'(sx_q) + 9'(col_q);
    assign py  = 8'(sy_q) + 8'(row_q);
    assign inb = (px < 9'(X_MAX)) && (py < 8'(Y_MAX));

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_vld_d = cnt_vld_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        erase_d   = erase_q;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (writeEn) begin
                    sx_d      = startx;
                    sy_d      = starty;
`ifdef SPRITE_ERASE_EN
                    erase_d   = erase;
`else
                    erase_d   = 1'b0;
`endif
                    col_d     = '0;
                    row_d     = '0;
                    cnt_vld_d = 1'b1;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!writeEn) begin
                    cnt_vld_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    // Leave once the last pixel has been presented on the outputs
                    if (out_last_q) begin
                        state_d = DONE;
                    end
                    if (cnt_vld_q) begin
                        issue = 1'b1;
                        if (last_col) begin
                            col_d = '0;
                            if (last_row) begin
                                cnt_vld_d = 1'b0;
                            end else begin
                                row_d = row_q + RW'(1);
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!writeEn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pipeline and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            cnt_vld_q  <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            erase_q    <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_inb_q   <= 1'b0;
            s1_body_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= 1'b0;
            plot_q     <= 1'b0;
            out_last_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_vld_q  <= cnt_vld_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            erase_q    <= erase_d;
            s1_vld_q   <= issue;
            s1_last_q  <= issue && last_col && last_row;
            if (issue) begin
                s1_inb_q  <= inb;
                s1_body_q <= body && !erase_q;
                s1_x_q    <= px[7:0];
                s1_y_q    <= py[6:0];
            end
            // Output stage always drains stage 1, so an abort still flushes one pixel
            x_q        <= s1_x_q;
            y_q        <= s1_y_q;
            colour_q   <= s1_body_q;
            plot_q     <= s1_vld_q && s1_inb_q;
            out_last_q <= s1_last_q;
            done_q     <= (state_d == DONE);
            busy_q     <= (state_d == SCAN);
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign done_print = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_draw_sprite_scan.sv
// Directed bench for draw_sprite_scan: table of prints plus hand sequences
// for handshake hold, abort and reset mid-scan.
module tb_draw_sprite_scan;

    logic       clock = 1'b0;
    logic       resetn;
    logic       writeEn;
    logic [7:0] startx;
    logic [6:0] starty;
    logic       erase;
    logic [7:0] x;
    logic [6:0] y;
    logic       colour;
    logic       plot;
    logic       done_print;
    logic       busy;

`ifdef SPRITE_ERASE_EN
    localparam int ER_TEST = 1;
`else
    localparam int ER_TEST = 0;
`endif

    draw_sprite_scan dut (
        .clock      (clock),
        .resetn     (resetn),
        .writeEn    (writeEn),
        .startx     (startx),
        .starty     (starty),
`ifdef SPRITE_ERASE_EN
        .erase      (erase),
`endif
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done_print (done_print),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int img [0:159][0:119];

    typedef struct {
        int sx;
        int sy;
        int er;
        int exp_plots;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference sprite: disc radius 10 centred at (10,10), mouth wedge to the right
    function automatic int shape(input int col, input int row, input int er);
        int dx, dy, ady, b;
        dx  = col - 10;
        dy  = row - 10;
        ady = (dy < 0) ? -dy : dy;
        b   = ((dx * dx + dy * dy) <= 100) && !((dx >= 1) && (2 * ady <= dx));
        return (er != 0) ? 0 : b;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                img[i][j] = -1;
    endtask

    // One full print; k is the index of the clock edge after the request (E0 = first)
    task automatic run_print(input int sx, input int sy, input int er,
                             output int plots, output int lat, output int perr);
        int n, col, row, px, py, ep;
        plots = 0;
        lat   = -1;
        perr  = 0;
        @(negedge clock);
        startx  = 8'(sx);
        starty  = 7'(sy);
        erase   = 1'(er);
        writeEn = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clock);
            #1;
            if (k >= 2 && k <= 401) begin
                n   = k - 2;
                col = n % 20;
                row = n / 20;
                px  = sx + col;
                py  = sy + row;
                ep  = (px < 160 && py < 120) ? 1 : 0;
                if (int'(plot) != ep) begin
                    perr++;
                end else if (plot && (x != 8'(px) || y != 7'(py) ||
                                      int'(colour) != shape(col, row, er))) begin
                    perr++;
                end
            end else if (plot) begin
                perr++;
            end
            if (plot) begin
                plots++;
                if (x < 8'd160 && y < 7'd120) img[x][y] = int'(colour);
            end
            if (k <= 401 && (busy !== 1'b1 || done_print !== 1'b0)) perr++;
            if (done_print === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_req(input string tag);
        @(negedge clock);
        writeEn = 1'b0;
        @(posedge clock);
        #1;
        check({tag, "_release_done"}, int'(done_print), 0);
        check({tag, "_release_busy"}, int'(busy), 0);
    endtask

    initial begin
        int plots, lat, perr, herr, aerr;
        vecs.push_back('{sx: 40,  sy: 50,  er: 0, exp_plots: 400});
        vecs.push_back('{sx: 150, sy: 0,   er: 0, exp_plots: 200});
        vecs.push_back('{sx: 150, sy: 110, er: 0, exp_plots: 100});
        vecs.push_back('{sx: 0,   sy: 0,   er: 0, exp_plots: 400});
        vecs.push_back('{sx: 159, sy: 119, er: 0, exp_plots: 1});
        vecs.push_back('{sx: 255, sy: 127, er: 0, exp_plots: 0});
`ifdef SPRITE_ERASE_EN
        vecs.push_back('{sx: 10,  sy: 10,  er: 1, exp_plots: 400});
`endif

        resetn  = 1'b0;
        writeEn = 1'b0;
        startx  = '0;
        starty  = '0;
        erase   = 1'b0;
        #12;
        check("reset_xy", int'(x) + int'(y), 0);
        check("reset_ctl", int'({colour, plot, done_print, busy}), 0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            clear_img();
            run_print(vecs[i].sx, vecs[i].sy, vecs[i].er, plots, lat, perr);
            check($sformatf("v%0d_plots", i), plots, vecs[i].exp_plots);
            check($sformatf("v%0d_latency", i), lat, 402);
            check($sformatf("v%0d_pixels", i), perr, 0);
            check($sformatf("v%0d_plot_in_done", i), int'(plot), 0);
            if (i == 0) begin
                check("probe_center", img[50][60], 1);
                check("probe_top", img[50][50], 1);
                check("probe_mouth", img[59][60], 0);
                check("probe_corner", img[40][50], 0);
            end
            release_req($sformatf("v%0d", i));
        end

        // Handshake hold: done stays up, no plots, no restart while writeEn high
        run_print(60, 20, 0, plots, lat, perr);
        check("hold_print_latency", lat, 402);
        herr = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (done_print !== 1'b1 || plot !== 1'b0 || busy !== 1'b0) herr++;
        end
        check("hold_errors", herr, 0);
        release_req("hold");
        run_print(61, 21, 0, plots, lat, perr);
        check("rerun_plots", plots, 400);
        check("rerun_latency", lat, 402);
        check("rerun_pixels", perr, 0);
        release_req("rerun");

        // Abort after 37 scan cycles: one drained pixel (index 36), then silence
        aerr = 0;
        @(negedge clock);
        startx  = 8'd0;
        starty  = 7'd0;
        writeEn = 1'b1;
        for (int k = 0; k <= 37; k++) begin
            @(posedge clock);
            #1;
            if (done_print !== 1'b0) aerr++;
        end
        @(negedge clock);
        writeEn = 1'b0;
        @(posedge clock);
        #1;
        check("abort_drain_plot", int'(plot), 1);
        check("abort_drain_xy", int'(x) * 256 + int'(y), 16 * 256 + 1);
        check("abort_drain_colour", int'(colour), 0);
        check("abort_busy", int'(busy), 0);
        for (int k = 39; k < 60; k++) begin
            @(posedge clock);
            #1;
            if (plot !== 1'b0 || done_print !== 1'b0 || busy !== 1'b0) aerr++;
        end
        check("abort_quiet", aerr, 0);

        // Reset mid-scan at index 123
        @(negedge clock);
        startx  = 8'd0;
        starty  = 7'd0;
        writeEn = 1'b1;
        for (int k = 0; k <= 123; k++) begin
            @(posedge clock);
            #1;
        end
        check("prereset_plot", int'(plot), 1);
        check("prereset_xy", int'(x) * 256 + int'(y), 1 * 256 + 6);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_xy", int'(x) + int'(y), 0);
        check("midreset_ctl", int'({colour, plot, done_print, busy}), 0);
        @(negedge clock);
        writeEn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        run_print(20, 30, ER_TEST, plots, lat, perr);
        check("postreset_plots", plots, 400);
        check("postreset_latency", lat, 402);
        check("postreset_pixels", perr, 0);
        release_req("postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_sprite_scan.md
# draw_sprite_scan

Pixel-stream responder for the sprite animation path. When the animation controller raises `writeEn` with a sprite origin, this block scans a fixed 20×20 right-facing Pac-Man sprite one pixel per clock. It emits VGA-adapter pixel writes (`x`, `y`, `colour`, `plot`) and then holds `done_print` until the controller releases `writeEn`. It sits between the animation FSM (the initiator) and the VGA adapter.

## Interface
- `WIDTH`, default 20: sprite columns.
- `HEIGHT`, default 20: sprite rows.
- `X_MAX`, default 160: screen width. Pixels with x ≥ X_MAX are clipped.
- `Y_MAX`, default 120: screen height. Pixels with y ≥ Y_MAX are clipped.
- `clock`  in  1: sole clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `writeEn`  in  1: level request. Held high by the initiator for the whole print.
- `startx`  in  8: sprite origin x. Sampled on request acceptance.
- `starty`  in  7: sprite origin y. Sampled on request acceptance.
- `x`  out  8: pixel x (registered).
- `y`  out  7: pixel y (registered).
- `colour`  out  1: 1 = sprite body, 0 = background (registered).
- `plot`  out  1: pixel write strobe to the VGA adapter (registered).
- `done_print`  out  1: print complete. Decoded from state.
- `busy`  out  1: high in SCAN.

## Operation
- **States:** IDLE, SCAN, DONE. Reset enters IDLE.
- **Reset values:** col = 0, row = 0, x = 0, y = 0, colour = 0, plot = 0, done_print = 0, busy = 0.
- **IDLE:**
  - If `writeEn`=1: latch `startx`/`starty`, clear col/row, go to SCAN.
  - Otherwise stay.
- **SCAN:**
  - Counters advance row-major: col 0..WIDTH-1, then row+1.
  - On col = WIDTH-1 and row = HEIGHT-1, go to DONE.
  - If `writeEn` falls mid-scan: abort to IDLE next edge. `done_print` stays 0. Pixels already queued in the output register still drain for one cycle.
- **DONE:**
  - `done_print`=1, `plot`=0.
  - Stay while `writeEn`=1. Return to IDLE on the edge where `writeEn`=0.
  - A new print needs `writeEn` low for at least one cycle; a re-raise is seen only in IDLE.
- **Shape**, per scanned (col,row):
  - dx = col − 10, dy = row − 10, signed 6-bit. Squares are computed in 8 bits unsigned.
  - Body when dx² + dy² ≤ 100, excluding the mouth.
  - Mouth: dx ≥ 1 and 2·|dy| ≤ dx.
  - `colour` = body.
- **Address arithmetic:**
  - px = startx + col, py = starty + row, each computed 1 bit wider than the output.
  - `plot`=1 only if px < X_MAX and py < Y_MAX. Out-of-bounds pixels still consume their cycle.
  - `x`/`y` carry the truncated px/py.
- **Output content:** every in-bounds pixel of the box is written, background included, so a print also erases the previous frame's trail inside the box.

## Timing
- Edge E0 samples `writeEn`=1 in IDLE. Edge E1: state = SCAN, index 0.
- Scan index n = row·WIDTH + col is loaded at edge E(n+1). It appears on `x`/`y`/`colour`/`plot` after edge E(n+2).
- Last pixel (n = 399) is presented after E401.
- After E402: state = DONE, `plot`=0, `done_print`=1.
- Total request-to-done latency: 402 cycles.
- `done_print` falls the cycle after the edge that sees `writeEn`=0.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously). No partial `done_print`.
- `startx`/`starty` changes after acceptance are ignored.

## Configuration
- `SPRITE_ERASE_EN` defined:
  - Adds input port `erase` (1 bit), sampled with `startx`/`starty` at acceptance.
  - When latched 1, `colour`=0 for every pixel. Clipping and timing are unchanged.
- Undefined:
  - No `erase` port; `colour` always follows the shape.

## Test plan
- **Basic print at origin.** Start (40,50). Expect:
  - (50,60) colour 1 (center).
  - (50,50) colour 1 (dx=0, dy=−10).
  - (59,60) colour 0 (mouth).
  - (40,50) colour 0 (corner).
  - 400 plots total, `done_print` after E402.
- **Handshake hold.** Keep `writeEn` high 10 cycles after `done_print`. Expect `done_print` held, no extra plots, and no restart until `writeEn` is low for one cycle.
- **Right-edge clipping.** Start (150,0). Expect exactly 200 plots, all with x ≤ 159, and cycle count unchanged at 402.
- **Bottom-right corner clipping.** Start (150,110). Expect 100 plots; `done_print` still asserted.
- **Abort.** Drop `writeEn` after 37 scan cycles. Expect return to IDLE, `done_print` never 1, no plots after the drain cycle.
- **Reset mid-scan.** Pull `resetn` low at scan index 123. Expect `plot`/`x`/`y`/`colour`/`busy` = 0 immediately, and a fresh request afterwards completes 400 pixels. With `SPRITE_ERASE_EN` and `erase`=1, all 400 pixels have colour 0.
